// File: rtl/spi_ahb_bridge.sv
// AHB-Lite register front end for the SPI master driver: TX byte FIFO, launch FSM, RX holding register, chip-select.
// Zero-wait-state bus; a start pulse follows a push by one cycle, and the FSM holds off launching while the driver is busy.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
endmodule

module spi_ahb_bridge #(
    parameter int   TX_DEPTH = 4,
    parameter logic CS_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        spi_start_o,
    output logic [7:0]  spi_data_o,
    input  logic        spi_busy_i,
    input  logic [7:0]  spi_data_i,
    output logic        spi_cs_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} state_t;

    state_t     state, state_nxt;
    logic       ahb_acc, dp_vld, dp_wr;
    logic [1:0] dp_addr;
    logic       wr_tx, wr_stat, wr_ctrl, rd_rx;
    logic       tx_pop, tx_push, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       capture, stat_busy;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ovr, tx_ovf;
    logic       unused_bits;

    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:8]};
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;

    assign ahb_acc = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dp_vld  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= 2'd0;
        end else begin
            dp_vld <= ahb_acc;
            if (ahb_acc) begin
                dp_wr   <= HWRITE;
                dp_addr <= HADDR[3:2];
            end
        end
    end

    assign wr_tx   = dp_vld & dp_wr  & (dp_addr == 2'd0);
    assign rd_rx   = dp_vld & ~dp_wr & (dp_addr == 2'd1);
    assign wr_stat = dp_vld & dp_wr  & (dp_addr == 2'd2);
    assign wr_ctrl = dp_vld & dp_wr  & (dp_addr == 2'd3);

    // A push into a full FIFO still lands if the FSM frees a slot in the same cycle.
    assign tx_push = wr_tx & (~tx_full | tx_pop);
    assign tx_pop  = spi_start_o;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (tx_push),
        .push_dat (HWDATA[7:0]),
        .pop_vld  (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (~tx_empty & ~spi_busy_i) state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (spi_busy_i)              state_nxt = WAIT_DONE;
            WAIT_DONE: if (~spi_busy_i)             state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_start_o = 1'b0;
        spi_data_o  = 8'h00;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (~tx_empty & ~spi_busy_i) begin
                    spi_start_o = 1'b1;
                    spi_data_o  = tx_head;
                end
            end
            WAIT_DONE: capture = ~spi_busy_i;
            default: ;
        endcase
    end

    // A capture beats a same-cycle RXDATA read-clear and is not counted as an overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
            spi_cs_o <= CS_RESET;
        end else begin
            if (capture) begin
                rx_data  <= spi_data_i;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (capture & rx_valid & ~rd_rx)  rx_ovr <= 1'b1;
            else if (wr_stat & HWDATA[4])     rx_ovr <= 1'b0;
            if (wr_tx & tx_full & ~tx_pop)    tx_ovf <= 1'b1;
            else if (wr_stat & HWDATA[5])     tx_ovf <= 1'b0;
            if (wr_ctrl)                      spi_cs_o <= HWDATA[0];
        end
    end

    assign stat_busy = (state != IDLE) | ~tx_empty;

    always_comb begin
        HRDATA = 32'h0;
        if (dp_vld & ~dp_wr) begin
            case (dp_addr)
                2'd1:    HRDATA = {24'h0, rx_data};
                2'd2:    HRDATA = {26'h0, tx_ovf, rx_ovr, rx_valid, tx_empty, tx_full, stat_busy};
                2'd3:    HRDATA = {31'h0, spi_cs_o};
                default: HRDATA = 32'h0;
            endcase
        end
    end
endmodule

// File: doc/spi_ahb_bridge.md
Name: spi_ahb_bridge

Overview:
AHB-Lite slave that sits directly upstream of the SPI master driver and lets the MIPSfpga core run byte transfers through memory-mapped registers. Written bytes are buffered in a small TX FIFO. A launch FSM issues one-cycle start pulses to the driver, waits for each transfer to complete, and captures the received byte into an RX holding register with status flags. The block also owns the software-controlled chip-select.

Parameters:
TX_DEPTH, 4, TX FIFO depth in bytes (power of two, 2..16)
CS_RESET, 1, reset value of spi_cs_o (1 = deselected)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
HSEL  in  1  AHB slave select
HADDR  in  32  AHB address; only [3:2] decoded
HTRANS  in  2  AHB transfer type; NONSEQ/SEQ are active
HWRITE  in  1  AHB write
HSIZE  in  3  AHB size; ignored, byte lane 0 used
HWDATA  in  32  AHB write data (data phase)
HREADY  in  1  AHB bus ready
HRDATA  out  32  AHB read data
HREADYOUT  out  1  always 1 (zero wait states)
HRESP  out  1  always 0 (OKAY)
spi_start_o  out  1  one-cycle start pulse to driver
spi_data_o  out  8  byte to transmit; valid while spi_start_o=1
spi_busy_i  in  1  driver busy
spi_data_i  in  8  driver received byte; valid once busy falls
spi_cs_o  out  1  chip-select to driver/slave, active-low

Behaviour:
- Reset (async, rst_i=1): FIFO empty; rx_data=0; rx_valid=0; rx_ovr=0; tx_ovf=0; spi_cs_o=CS_RESET; spi_start_o=0; spi_data_o=0; HRDATA=0; FSM=IDLE. Reset mid-transfer abandons the transfer with no capture.
- AHB address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, latch addr[3:2] and HWRITE. The write takes effect in the next (data) cycle using HWDATA[7:0]. HRDATA is combinational from the latched read address during the data phase; it is 0 when no read is pending.
- Register map (word offsets):
  - 0x0 TXDATA: W pushes HWDATA[7:0]; R reads 0.
  - 0x4 RXDATA: R returns {24'b0, rx_data}; a read clears rx_valid in the data-phase cycle; W is ignored.
  - 0x8 STATUS: R bits are [0] busy (FSM!=IDLE or FIFO non-empty), [1] tx_full, [2] tx_empty, [3] rx_valid, [4] rx_ovr, [5] tx_ovf. W: write-1-to-clear bits 4 and 5.
  - 0xC CTRL: R/W; bit0 = spi_cs_o.
- TX FIFO push when not full. Push while full: byte dropped, tx_ovf set, except when a pop happens in the same cycle, in which case the push is accepted. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo TX_DEPTH; count width is clog2(TX_DEPTH)+1.
- Launch FSM:
  - IDLE: if FIFO non-empty and spi_busy_i=0, assert spi_start_o for exactly 1 cycle, drive spi_data_o=head byte, pop, go to WAIT_BUSY.
  - WAIT_BUSY: wait for spi_busy_i=1, then go to WAIT_DONE.
  - WAIT_DONE: on spi_busy_i=0, set rx_data<=spi_data_i, then go to IDLE. If rx_valid was already 1 and is not cleared this cycle, set rx_ovr. Set rx_valid=1.
- A capture in the same cycle as an RXDATA read-clear wins: rx_valid=1, rx_ovr unchanged.
- Minimum gap between consecutive start pulses is one transfer plus 1 IDLE cycle. spi_start_o never asserts outside IDLE.
- spi_cs_o changes only on CTRL writes, never automatically. Software must keep it low for the whole transfer.

Test Plan:
- Reset values: after reset, read STATUS -> 0x04; CTRL -> 0x01; RXDATA -> 0x00; spi_start_o never pulsed.
- Single transfer with a driver model: write CTRL=0, write TXDATA=0xA5, model echoes 0x3C -> one start pulse with spi_data_o=0xA5; STATUS bit3=1; RXDATA=0x3C; STATUS bit3=0 after that read.
- FIFO fill: with busy held high, write 0x01..0x05 -> first 4 accepted, tx_full=1, tx_ovf=1. Release busy -> start pulses carry 0x01,0x02,0x03,0x04 in order; write STATUS=0x20 clears tx_ovf.
- Overrun: two transfers without reading RXDATA -> rx_ovr=1, RXDATA = second byte. Write STATUS=0x10 -> rx_ovr=0.
- Simultaneous events: push to a full FIFO in the same cycle as an FSM pop -> accepted, count stays 4, tx_ovf=0. RXDATA read in the capture cycle -> rx_valid=1, rx_ovr=0.
- Async reset in WAIT_DONE: assert rst_i between clock edges -> outputs return to reset values immediately; no capture occurs; next transfer after release works normally.
